mem_bus_arbiter: RTL and testbench

- Shares one sram-like memory port between instruction fetch (IF) and the MEM-stage data access (load/store/LL/SC path).
- Sits between the pipeline and the cache/AXI bridge. Owns the single outstanding bus transaction and routes handshakes back to the owning requester.
- Data side has priority. A streak counter bounds fetch starvation.

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_grant.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_bus_arbiter_pkg;

  // Width of every read/write data path on the shared port.
  localparam int DATA_W = 32;

  // Wide enough for a data-burst bound of up to 15.
  localparam int STREAK_W = 4;

  // Memory access sizes as carried on data_size / bus_size.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing owns the bus
    ADDR = 2'd1,  // owner's request is presented on the bus
    WAIT = 2'd2   // address accepted, waiting for the response
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// Grant decision for the memory-port arbiter: data side wins unless fetch has
// already been passed over MAX_DATA_BURST times in a row.
module mem_bus_arbiter_grant
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_vld,
  output logic                grant_data,
  output logic [STREAK_W-1:0] streak_next
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

  // Streak increment that never runs past the burst bound.
  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    logic [STREAK_W-1:0] r;
    if (v >= STREAK_MAX) begin
      r = STREAK_MAX;
    end else begin
      r = v + STREAK_W'(1);
    end
    return r;
  endfunction

  logic inst_due;

  // Priority pick: a waiting fetch only overrides data once the streak is full.
  always_comb begin
    inst_due    = inst_req && (streak == STREAK_MAX);
    grant_vld   = 1'b0;
    grant_data  = 1'b0;
    streak_next = streak;
    if (data_req && !inst_due) begin
      grant_vld   = 1'b1;
      grant_data  = 1'b1;
      // Only grants that actually pass over a waiting fetch count.
      streak_next = inst_req ? sat_inc(streak) : '0;
    end else if (inst_req) begin
      grant_vld   = 1'b1;
      grant_data  = 1'b0;
      streak_next = '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like memory port between instruction fetch and the MEM-stage
// data access. Owns the single outstanding bus transaction and routes the
// address/data handshakes back to whichever side was granted.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic                grant_vld;
  logic                grant_data;
  logic [STREAK_W-1:0] streak_next;
  logic                take_grant;
  logic                owner_req;

  mem_bus_arbiter_grant #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_grant (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .streak      (streak_q),
    .grant_vld   (grant_vld),
    .grant_data  (grant_data),
    .streak_next (streak_next)
  );

  // Live request of the current owner; dropping it in ADDR means a flush.
  always_comb begin
    owner_req = (owner_q == OWN_DATA) ? data_req : inst_req;
  end

  // Next state: grants are taken in IDLE, or in WAIT on the response so the
  // next owner reaches the bus without an idle bubble.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    take_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        take_grant = 1'b1;
      end
      ADDR: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (bus_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          take_grant = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take_grant) begin
      if (grant_vld) begin
        state_d  = ADDR;
        owner_d  = grant_data ? OWN_DATA : OWN_INST;
        streak_d = streak_next;
      end else begin
        state_d  = IDLE;
      end
    end
  end

  // Bus fields and handshake routing; everything not owned stays at zero.
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = SIZE_BYTE;
    bus_wstrb    = 4'b0000;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    if ((state_q == ADDR) && owner_req) begin
      bus_req = 1'b1;
      if (owner_q == OWN_DATA) begin
        bus_wr       = data_wr;
        bus_size     = data_size;
        bus_wstrb    = data_sel;
        bus_addr     = data_addr;
        bus_wdata    = data_wdata;
        data_addr_ok = bus_addr_ok;
      end else begin
        bus_wr       = 1'b0;
        bus_size     = SIZE_WORD;
        bus_wstrb    = 4'b0000;
        bus_addr     = inst_addr;
        inst_addr_ok = bus_addr_ok;
      end
    end

    // A response outside WAIT has no transaction to belong to and is dropped.
    if ((state_q == WAIT) && bus_data_ok) begin
      if (owner_q == OWN_DATA) begin
        data_data_ok = 1'b1;
        data_rdata   = bus_rdata;
      end else begin
        inst_data_ok = 1'b1;
        inst_rdata   = bus_rdata;
      end
    end
  end

  // Arbiter state; reset abandons any in-flight transaction immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INST;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int ADDR_W         = 32;
  localparam int MAX_DATA_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok, inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_sel;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [31:0]       data_rdata;
  logic              bus_req, bus_wr;
  logic [1:0]        bus_size;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_addr_ok, bus_data_ok;
  logic [31:0]       bus_rdata;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"},      32'(bus_req),      32'd0);
    chk({tag, "_bus_wr"},       32'(bus_wr),       32'd0);
    chk({tag, "_bus_size"},     32'(bus_size),     32'd0);
    chk({tag, "_bus_wstrb"},    32'(bus_wstrb),    32'd0);
    chk({tag, "_bus_addr"},     bus_addr,          32'd0);
    chk({tag, "_bus_wdata"},    bus_wdata,         32'd0);
    chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
    chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'd0);
    chk({tag, "_inst_rdata"},   inst_rdata,        32'd0);
    chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'd0);
    chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'd0);
    chk({tag, "_data_rdata"},   data_rdata,        32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Transaction view: phase 0 = no transaction, 1 = requesting, 2 = accepted.
  // who: 0 = fetch, 1 = data. burst = data grants in a row that passed a fetch.
  int m_phase = 0;
  int m_who   = 0;
  int m_burst = 0;
  int m_log[$];
  logic m_own_req;
  assign m_own_req = (m_who == 1) ? data_req : inst_req;

  function automatic int pick(input logic ir, input logic dr, input int burst);
    if (dr && !(ir && burst == MAX_DATA_BURST)) return 1;
    if (ir) return 0;
    return -1;
  endfunction

  function automatic int next_burst(input int g, input logic ir, input int b);
    if (g == 1 && ir) return (b >= MAX_DATA_BURST) ? MAX_DATA_BURST : b + 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_who   <= 0;
      m_burst <= 0;
    end else if (m_phase == 0 || (m_phase == 2 && bus_data_ok)) begin
      if (pick(inst_req, data_req, m_burst) < 0) begin
        m_phase <= 0;
      end else begin
        m_phase <= 1;
        m_who   <= pick(inst_req, data_req, m_burst);
        m_burst <= next_burst(pick(inst_req, data_req, m_burst), inst_req, m_burst);
        m_log.push_back(pick(inst_req, data_req, m_burst));
      end
    end else if (m_phase == 1) begin
      if (!m_own_req) m_phase <= 0;
      else if (bus_addr_ok) m_phase <= 2;
    end
  end

  logic        e_bus_req, e_bus_wr, e_ia_ok, e_id_ok, e_da_ok, e_dd_ok;
  logic [1:0]  e_bus_size;
  logic [3:0]  e_bus_wstrb;
  logic [31:0] e_bus_addr, e_bus_wdata, e_irdata, e_drdata;

  always_comb begin
    e_bus_req = 1'b0; e_bus_wr = 1'b0; e_bus_size = 2'd0; e_bus_wstrb = 4'd0;
    e_bus_addr = 32'd0; e_bus_wdata = 32'd0;
    e_ia_ok = 1'b0; e_id_ok = 1'b0; e_da_ok = 1'b0; e_dd_ok = 1'b0;
    e_irdata = 32'd0; e_drdata = 32'd0;
    if (m_phase == 1 && m_own_req) begin
      e_bus_req = 1'b1;
      if (m_who == 1) begin
        e_bus_wr = data_wr; e_bus_size = data_size; e_bus_wstrb = data_sel;
        e_bus_addr = data_addr; e_bus_wdata = data_wdata; e_da_ok = bus_addr_ok;
      end else begin
        e_bus_size = 2'd2; e_bus_addr = inst_addr; e_ia_ok = bus_addr_ok;
      end
    end
    if (m_phase == 2 && bus_data_ok) begin
      if (m_who == 1) begin e_dd_ok = 1'b1; e_drdata = bus_rdata; end
      else begin e_id_ok = 1'b1; e_irdata = bus_rdata; end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("cmp_bus_req",      32'(bus_req),      32'(e_bus_req));
    chk("cmp_inst_addr_ok", 32'(inst_addr_ok), 32'(e_ia_ok));
    chk("cmp_inst_data_ok", 32'(inst_data_ok), 32'(e_id_ok));
    chk("cmp_inst_rdata",   inst_rdata,        e_irdata);
    chk("cmp_data_addr_ok", 32'(data_addr_ok), 32'(e_da_ok));
    chk("cmp_data_data_ok", 32'(data_data_ok), 32'(e_dd_ok));
    chk("cmp_data_rdata",   data_rdata,        e_drdata);
    if (e_bus_req) begin
      chk("cmp_bus_wr",    32'(bus_wr),    32'(e_bus_wr));
      chk("cmp_bus_size",  32'(bus_size),  32'(e_bus_size));
      chk("cmp_bus_wstrb", 32'(bus_wstrb), 32'(e_bus_wstrb));
      chk("cmp_bus_addr",  bus_addr,       e_bus_addr);
      if (m_who == 1) chk("cmp_bus_wdata", bus_wdata, e_bus_wdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_sel = 4'd0;
    data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    #1 rst = 1'b0;
    #2 chk_all_zero("reset");
    cyc(); cyc();
    rst = 1'b1;

    // Lone load
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_sel = 4'hF;
    data_addr = 32'h1000_0004;
    #2 chk("load_c0_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1;
    #2 chk("load_c1_bus_req", 32'(bus_req), 32'd1);
    chk("load_bus_addr", bus_addr, 32'h1000_0004);
    chk("load_bus_size", 32'(bus_size), 32'd2);
    chk("load_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("load_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b0;
    #2 chk("load_wait_bus_req", 32'(bus_req), 32'd0);
    cyc();
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #2 chk("load_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("load_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("load_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("load_inst_rdata", inst_rdata, 32'd0);
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0;
    #2 chk("load_after_data_ok", 32'(data_data_ok), 32'd0);

    // Contention: data first, fetch regranted on data's response
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    data_req = 1'b1; data_addr = 32'h0000_3000;
    #2 chk("cont_c0_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1;
    #2 chk("cont_first_addr", bus_addr, 32'h0000_3000);
    chk("cont_first_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("cont_first_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b0;
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h1111_0000;
    #2 chk("cont_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("cont_data_rdata", data_rdata, 32'h1111_0000);
    cyc(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    #2 chk("cont_no_bubble_bus_req", 32'(bus_req), 32'd1);
    chk("cont_inst_addr", bus_addr, 32'h0000_2000);
    chk("cont_inst_size", 32'(bus_size), 32'd2);
    chk("cont_inst_wstrb", 32'(bus_wstrb), 32'd0);
    chk("cont_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0;
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h0000_2222;
    #2 chk("cont_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("cont_inst_rdata", inst_rdata, 32'h0000_2222);
    chk("cont_data_rdata_zero", data_rdata, 32'd0);
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0;

    // Starvation bound with both requests held
    m_log.delete();
    inst_req = 1'b1; inst_addr = 32'h0000_5000;
    data_req = 1'b1; data_addr = 32'h0000_6000;
    cyc();
    for (int i = 0; i < 10; i++) begin
      bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
      #2 chk($sformatf("burst%0d_data_addr_ok", i), 32'(data_addr_ok), 32'(exp_order[i]));
      chk($sformatf("burst%0d_inst_addr_ok", i), 32'(inst_addr_ok), 32'(1 - exp_order[i]));
      cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      if (i == 9) begin inst_req = 1'b0; data_req = 1'b0; end
      cyc();
    end
    bus_data_ok = 1'b0;
    chk("model_log_len", 32'(m_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < m_log.size(); i++)
      chk($sformatf("model_order%0d", i), 32'(m_log[i]), 32'(exp_order[i]));

    // Store fields
    data_req = 1'b1; data_wr = 1'b1; data_sel = 4'b0010; data_size = 2'd0;
    data_wdata = 32'h0000_AB00; data_addr = 32'h0000_4001;
    #2 chk("store_c0_bus_req", 32'(bus_req), 32'd0);
    cyc();
    #2 chk("store_bus_wr", 32'(bus_wr), 32'd1);
    chk("store_bus_wstrb", 32'(bus_wstrb), 32'b0010);
    chk("store_bus_size", 32'(bus_size), 32'd0);
    chk("store_bus_wdata", bus_wdata, 32'h0000_AB00);
    chk("store_early_addr_ok", 32'(data_addr_ok), 32'd0);
    cyc(); bus_addr_ok = 1'b1;
    #2 chk("store_data_addr_ok", 32'(data_addr_ok), 32'd1);
    cyc(); data_req = 1'b0; data_wr = 1'b0; bus_addr_ok = 1'b0;
    cyc(); bus_data_ok = 1'b1;
    #2 chk("store_data_data_ok", 32'(data_data_ok), 32'd1);
    cyc(); bus_data_ok = 1'b0;

    // Flush in ADDR, then a stray response
    data_req = 1'b1; data_addr = 32'h0000_7000; data_size = 2'd2; data_sel = 4'hF;
    cyc();
    #2 chk("flush_bus_req_up", 32'(bus_req), 32'd1);
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b1;
    #2 chk("flush_bus_req_down", 32'(bus_req), 32'd0);
    chk("flush_no_addr_ok", 32'(data_addr_ok), 32'd0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0BAD;
    #2 chk("flush_stray_data_ok", 32'(data_data_ok), 32'd0);
    chk("flush_stray_inst_ok", 32'(inst_data_ok), 32'd0);
    chk("flush_stray_rdata", data_rdata, 32'd0);
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0;

    // Asynchronous reset while waiting on a response
    inst_req = 1'b1; inst_addr = 32'h0000_8000;
    cyc(); bus_addr_ok = 1'b1;
    #2 chk("rst_pre_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0;
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h0000_5555;
    #1 rst = 1'b0;
    #1 chk_all_zero("rst_wait");
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0;
    #1 rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0000_9000;
    #1 chk("post_rst_c0_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1;
    #2 chk("post_rst_bus_req", 32'(bus_req), 32'd1);
    chk("post_rst_bus_addr", bus_addr, 32'h0000_9000);
    chk("post_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0;
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h0000_600D;
    #2 chk("post_rst_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("post_rst_inst_rdata", inst_rdata, 32'h0000_600D);
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
